// File: rtl/mem_stage.sv
// Pipeline MEM stage: passes ALU results through in one cycle and runs loads and
// stores as a single outstanding data-memory request, stalling upstream until done.
module mem_stage #(
    parameter int unsigned TIMEOUT_MAX = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] alu_res_in,
    input  logic [31:0] opb_in,
    input  logic [7:0]  ctrl_in,
    input  logic [4:0]  regw_addr_in,
    input  logic        wb_wen_in,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        stall_out,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] wb_data_out,
    output logic [4:0]  regw_addr_out,
    output logic        wb_wen_out,
    output logic [7:0]  ctrl_out,
    output logic        misalign_out,
    output logic        timeout_out
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [7:0] TMAX = 8'(TIMEOUT_MAX);

    state_t      state;
    state_t      state_nxt;
    logic        stall_c;
    logic        mem_op;
    logic        aligned;
    logic        ack_hit;
    logic        tout_hit;
    logic [7:0]  wait_cnt;
    logic [31:0] rdata_q;

    assign mem_op  = valid_in & (ctrl_in[0] | ctrl_in[1]);
    assign aligned = (alu_res_in[1:0] == 2'b00);
    assign ack_hit = (state == REQ) & dm_ack;
    // An ack in the timeout cycle wins, so the timeout only fires without one.
    assign tout_hit = (state == REQ) & ~dm_ack &
                      (({1'b0, wait_cnt} + 9'd1) >= {1'b0, TMAX});

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        stall_c   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op && aligned) begin
                    state_nxt = REQ;
                    stall_c   = 1'b1;
                end
            end
            REQ: begin
                stall_c = 1'b1;
                if (ack_hit || tout_hit) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stall must read low while reset is held, even if upstream presents a mem op.
    assign stall_out = stall_c & rst;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // NOTE: the rdata holding register and the wait counter are plain flops, so they are reset like any output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dm_req        <= 1'b0;
            dm_we         <= 1'b0;
            dm_addr       <= '0;
            dm_wdata      <= '0;
            valid_out     <= 1'b0;
            pc_out        <= '0;
            wb_data_out   <= '0;
            regw_addr_out <= '0;
            wb_wen_out    <= 1'b0;
            ctrl_out      <= '0;
            misalign_out  <= 1'b0;
            timeout_out   <= 1'b0;
            wait_cnt      <= '0;
            rdata_q       <= '0;
        end else begin
            misalign_out <= 1'b0;
            timeout_out  <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_op && aligned) begin
                        dm_req    <= 1'b1;
                        dm_we     <= ctrl_in[1];
                        dm_addr   <= {alu_res_in[31:2], 2'b00};
                        dm_wdata  <= opb_in;
                        wait_cnt  <= '0;
                        valid_out <= 1'b0;
                    end else begin
                        // Misaligned mem ops flow through without writeback.
                        valid_out     <= valid_in;
                        pc_out        <= pc_in;
                        wb_data_out   <= alu_res_in;
                        regw_addr_out <= regw_addr_in;
                        wb_wen_out    <= wb_wen_in & ~mem_op;
                        ctrl_out      <= ctrl_in;
                        misalign_out  <= mem_op;
                    end
                end
                REQ: begin
                    valid_out <= 1'b0;
                    if (ack_hit) begin
                        rdata_q <= dm_rdata;
                        dm_req  <= 1'b0;
                        dm_we   <= 1'b0;
                    end else begin
                        wait_cnt <= (wait_cnt >= TMAX) ? TMAX : wait_cnt + 8'd1;
                        if (tout_hit) begin
                            dm_req      <= 1'b0;
                            dm_we       <= 1'b0;
                            rdata_q     <= '0;
                            timeout_out <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Upstream is still frozen here, so the inputs describe this instruction.
                    valid_out     <= 1'b1;
                    pc_out        <= pc_in;
                    wb_data_out   <= ctrl_in[2] ? rdata_q : alu_res_in;
                    regw_addr_out <= regw_addr_in;
                    wb_wen_out    <= wb_wen_in & ~timeout_out;
                    ctrl_out      <= ctrl_in;
                end
                default: begin
                    valid_out <= 1'b0;
                    dm_req    <= 1'b0;
                    dm_we     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes expected MEM/WB records into a
// scoreboard queue, and a monitor pops and compares them whenever valid_out is high.
module tb_mem_stage;

    localparam int TMAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [31:0] pc_in, alu_res_in, opb_in;
    logic [7:0]  ctrl_in;
    logic [4:0]  regw_addr_in;
    logic        wb_wen_in;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        stall_out, valid_out;
    logic [31:0] pc_out, wb_data_out;
    logic [4:0]  regw_addr_out;
    logic        wb_wen_out;
    logic [7:0]  ctrl_out;
    logic        misalign_out, timeout_out;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        wen;
        logic [7:0]  ctrl;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    mem_stage #(.TIMEOUT_MAX(TMAX)) dut (
        .clk(clk), .rst(rst),
        .valid_in(valid_in), .pc_in(pc_in), .alu_res_in(alu_res_in), .opb_in(opb_in),
        .ctrl_in(ctrl_in), .regw_addr_in(regw_addr_in), .wb_wen_in(wb_wen_in),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .stall_out(stall_out), .valid_out(valid_out), .pc_out(pc_out),
        .wb_data_out(wb_data_out), .regw_addr_out(regw_addr_out), .wb_wen_out(wb_wen_out),
        .ctrl_out(ctrl_out), .misalign_out(misalign_out), .timeout_out(timeout_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [7:0] ctrl,
                         input logic [31:0] alu, input logic [31:0] opb,
                         input logic [4:0] rd, input logic wen);
        valid_in     = v;
        pc_in        = pc;
        ctrl_in      = ctrl;
        alu_res_in   = alu;
        opb_in       = opb;
        regw_addr_in = rd;
        wb_wen_in    = wen;
    endtask

    task automatic drive_idle();
        drive(1'b0, 32'h0, 8'h00, 32'h0, 32'h0, 5'd0, 1'b0);
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] data, input logic [4:0] rd,
                        input logic wen, input logic [7:0] ctrl);
        exp_t e;
        e.pc = pc; e.data = data; e.rd = rd; e.wen = wen; e.ctrl = ctrl;
        sb.push_back(e);
    endtask

    // Non-mem (or misaligned) instruction: result appears one cycle later, no stall.
    task automatic alu_op(input logic [31:0] pc, input logic [7:0] ctrl, input logic [31:0] alu,
                          input logic [4:0] rd, input logic wen, input logic [31:0] exp_data,
                          input logic exp_wen, input logic exp_mis);
        drive(1'b1, pc, ctrl, alu, 32'h1111_2222, rd, wen);
        push(pc, exp_data, rd, exp_wen, ctrl);
        #1 check("pass_stall_n0", stall_out, 1'b0);
        @(negedge clk);
        check("pass_valid", valid_out, 1'b1);
        check("pass_misalign", misalign_out, exp_mis);
        check("pass_no_req", dm_req, 1'b0);
        drive_idle();
        #1 check("pass_stall_n1", stall_out, 1'b0);
        @(negedge clk);
        check("misalign_one_cycle", misalign_out, 1'b0);
    endtask

    // Aligned mem op; ack_cyc = REQ cycle (1-based) carrying dm_ack, 0 for never.
    task automatic mem_op(input logic [31:0] pc, input logic [7:0] ctrl, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd, input logic wen,
                          input int ack_cyc, input logic [31:0] rdata,
                          input logic [31:0] exp_data, input logic exp_wen, input logic exp_to);
        drive(1'b1, pc, ctrl, addr, wdata, rd, wen);
        push(pc, exp_data, rd, exp_wen, ctrl);
        #1 check("accept_stall", stall_out, 1'b1);
        for (int i = 1; i <= TMAX; i++) begin
            @(negedge clk);
            check("req_dm_req", dm_req, 1'b1);
            check("req_stall", stall_out, 1'b1);
            check("req_valid_low", valid_out, 1'b0);
            check("req_addr", dm_addr, addr);
            check("req_we", dm_we, ctrl[1]);
            check("req_wdata", dm_wdata, wdata);
            if (i == ack_cyc) begin
                dm_ack   = 1'b1;
                dm_rdata = rdata;
                break;
            end
        end
        @(negedge clk);
        dm_ack   = 1'b0;
        dm_rdata = 32'hFFFF_FFFF;
        check("done_stall", stall_out, 1'b0);
        check("done_req_low", dm_req, 1'b0);
        check("done_timeout", timeout_out, exp_to);
        check("done_valid_low", valid_out, 1'b0);
        @(negedge clk);
        check("result_valid", valid_out, 1'b1);
        check("timeout_one_cycle", timeout_out, 1'b0);
        drive_idle();
        @(negedge clk);
        check("back_idle_valid", valid_out, 1'b0);
    endtask

    // Scoreboard monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && valid_out) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid_out", valid_out, 1'b0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_pc", pc_out, e.pc);
                    check("sb_wb_data", wb_data_out, e.data);
                    check("sb_regw", {27'd0, regw_addr_out}, {27'd0, e.rd});
                    check("sb_wen", wb_wen_out, e.wen);
                    check("sb_ctrl", {24'd0, ctrl_out}, {24'd0, e.ctrl});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        dm_ack   = 1'b0;
        dm_rdata = 32'h0;
        // A mem op presented during reset must not raise stall or start a request.
        drive(1'b1, 32'h4, 8'h01, 32'h40, 32'h0, 5'd1, 1'b1);
        repeat (2) @(negedge clk);
        check("rst_stall", stall_out, 1'b0);
        check("rst_dm_req", dm_req, 1'b0);
        check("rst_valid", valid_out, 1'b0);
        check("rst_wb_data", wb_data_out, 32'h0);
        check("rst_wen", wb_wen_out, 1'b0);
        check("rst_misalign", misalign_out, 1'b0);
        check("rst_timeout", timeout_out, 1'b0);
        drive_idle();
        rst = 1'b1;
        @(negedge clk);

        // ALU op, with a stray ack that must be ignored.
        dm_ack = 1'b1;
        alu_op(32'h10, 8'h00, 32'h0000_1234, 5'd5, 1'b1, 32'h0000_1234, 1'b1, 1'b0);
        dm_ack = 1'b0;

        // valid_in low with mem_read set: nothing may start.
        drive(1'b0, 32'h14, 8'h01, 32'h200, 32'h0, 5'd6, 1'b1);
        #1 check("novalid_stall", stall_out, 1'b0);
        @(negedge clk);
        check("novalid_req", dm_req, 1'b0);
        check("novalid_valid", valid_out, 1'b0);
        drive_idle();
        @(negedge clk);

        // Load, ack in the second REQ cycle.
        mem_op(32'h20, 8'h05, 32'h100, 32'h0, 5'd7, 1'b1, 2, 32'hDEAD_BEEF,
               32'hDEAD_BEEF, 1'b1, 1'b0);
        // Store, ack in the third REQ cycle; result is the ALU address.
        mem_op(32'h24, 8'h02, 32'h204, 32'hA5A5_A5A5, 5'd0, 1'b0, 3, 32'h0,
               32'h204, 1'b0, 1'b0);
        // Misaligned load.
        alu_op(32'h28, 8'h05, 32'h102, 5'd8, 1'b1, 32'h102, 1'b0, 1'b1);
        // Zero-wait load with pass-through control bits.
        mem_op(32'h2C, 8'hA5, 32'h10, 32'h0, 5'd9, 1'b1, 1, 32'h0BAD_F00D,
               32'h0BAD_F00D, 1'b1, 1'b0);
        // No ack: timeout after TMAX REQ cycles, writeback suppressed.
        mem_op(32'h30, 8'h01, 32'h300, 32'h0, 5'd10, 1'b1, 0, 32'h0,
               32'h300, 1'b0, 1'b1);
        // Ack in the timeout cycle counts as an ack.
        mem_op(32'h34, 8'h05, 32'h304, 32'h0, 5'd11, 1'b1, TMAX, 32'h0000_55AA,
               32'h0000_55AA, 1'b1, 1'b0);

        // Reset pulled during REQ abandons the access.
        drive(1'b1, 32'h38, 8'h05, 32'h400, 32'h0, 5'd12, 1'b1);
        @(negedge clk);
        check("abort_req_before", dm_req, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("abort_req_async", dm_req, 1'b0);
        check("abort_stall", stall_out, 1'b0);
        drive_idle();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        alu_op(32'h3C, 8'h00, 32'h0000_CAFE, 5'd13, 1'b1, 32'h0000_CAFE, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
